toggle_gen: RTL and testbench

- Parametrised, programmable toggle generator; successor to the single-bit toggle flip-flop.
- Divides `clk` by a runtime half-period and toggles `out` at that rate, either continuously or for a programmed burst of toggles.
- Keeps manual single-toggle operation while idle.
- Used for baud and bit-timing strobes and for test square waves in the UART path.

---
 rtl/toggle_gen_pkg.sv | 12 +
 rtl/toggle_gen_half_period_counter.sv | 30 +++
 rtl/toggle_gen.sv | 122 ++++++++++++
 tb/tb_toggle_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_gen_pkg.sv
// Shared types and constants for the programmable toggle generator.
package toggle_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/toggle_gen_half_period_counter.sv
// Half-period divisor counter: counts enabled cycles and flags when it reaches div.
module half_period_counter #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] cnt,
  output logic             tc
);

  logic [DIV_W-1:0] cnt_q;

  assign tc  = (cnt_q == div);
  assign cnt = cnt_q;

  // Clear wins over counting; wrap to zero on terminal count so cnt never exceeds div.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/toggle_gen.sv
// Programmable toggle generator: continuous or burst square wave with manual toggle in idle.
module toggle_gen
  import toggle_gen_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned CNT_W      = 8,
  parameter logic        INIT_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             mode,
  input  logic             toggle,
  output logic             out,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             mode_q, mode_d;

  logic             cnt_en;
  logic             cnt_clr;
  logic             cnt_tc;
  logic [DIV_W-1:0] cnt_val;

  half_period_counter #(
    .DIV_W(DIV_W)
  ) u_half_period_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .clear(cnt_clr),
    .div  (div_q),
    .cnt  (cnt_val),
    .tc   (cnt_tc)
  );

  // Next-state: stop beats load, load beats toggle; toggle only acts in IDLE.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    rem_d   = rem_q;
    div_d   = div_q;
    mode_d  = mode_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;

    if (stop) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else if (load) begin
      div_d   = div;
      mode_d  = mode;
      rem_d   = burst_len;
      cnt_clr = 1'b1;
      // An empty burst completes immediately without ever entering RUN.
      if (mode == MODE_BURST && burst_len == '0) begin
        done_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == IDLE) begin
      if (toggle) begin
        out_d  = ~out_q;
        tick_d = 1'b1;
      end
    end else if (en) begin
      cnt_en = 1'b1;
      if (cnt_tc) begin
        out_d  = ~out_q;
        tick_d = 1'b1;
        if (mode_q == MODE_BURST) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      out_q   <= INIT_LEVEL;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
      div_q   <= '0;
      mode_q  <= MODE_CONT;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
    end
  end

  assign out  = out_q;
  assign tick = tick_q;
  assign done = done_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_toggle_gen.sv
// Self-checking bench for toggle_gen against a toggle-count reference model.
module tb_toggle_gen;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             load;
  logic             stop;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] burst_len;
  logic             mode;
  logic             toggle;
  logic             out;
  logic             tick;
  logic             busy;
  logic             done;

  int vectors = 0;
  int fails   = 0;

  // Reference model: toggles fall on every (div+1)-th enabled edge since load.
  bit m_run;
  bit m_out;
  bit m_tick;
  bit m_done;
  int m_div;
  bit m_mode;
  int m_len;
  int m_edges;
  int m_toggles;

  toggle_gen #(
    .DIV_W     (DIV_W),
    .CNT_W     (CNT_W),
    .INIT_LEVEL(1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .stop     (stop),
    .div      (div),
    .burst_len(burst_len),
    .mode     (mode),
    .toggle   (toggle),
    .out      (out),
    .tick     (tick),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run     = 1'b0;
    m_out     = 1'b0;
    m_tick    = 1'b0;
    m_done    = 1'b0;
    m_div     = 0;
    m_mode    = 1'b0;
    m_len     = 0;
    m_edges   = 0;
    m_toggles = 0;
  endtask

  task automatic model_update();
    m_tick = 1'b0;
    m_done = 1'b0;
    if (stop) begin
      m_run = 1'b0;
    end else if (load) begin
      m_div     = int'(div);
      m_mode    = mode;
      m_len     = int'(burst_len);
      m_edges   = 0;
      m_toggles = 0;
      if (mode && burst_len == 0) begin
        m_done = 1'b1;
        m_run  = 1'b0;
      end else begin
        m_run = 1'b1;
      end
    end else if (!m_run) begin
      if (toggle) begin
        m_out  = ~m_out;
        m_tick = 1'b1;
      end
    end else if (en) begin
      m_edges++;
      if (m_edges % (m_div + 1) == 0) begin
        m_out  = ~m_out;
        m_tick = 1'b1;
        m_toggles++;
        if (m_mode && m_toggles == m_len) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  // One clock: predict, clock, compare 1ns after the edge, then drop strobes.
  task automatic step();
    if (!rst) model_reset();
    else model_update();
    @(posedge clk);
    #1;
    check("out", out, m_out);
    check("tick", tick, m_tick);
    check("busy", busy, m_run);
    check("done", done, m_done);
    load   = 1'b0;
    stop   = 1'b0;
    toggle = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input int d, input int len, input logic m);
    div       = DIV_W'(d);
    burst_len = CNT_W'(len);
    mode      = m;
    load      = 1'b1;
    step();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b1;
    load      = 1'b0;
    stop      = 1'b0;
    div       = '0;
    burst_len = '0;
    mode      = 1'b0;
    toggle    = 1'b0;
    model_reset();

    // Reset held for three cycles, then continuous div=3.
    steps(3);
    rst = 1'b1;
    step();
    do_load(3, 0, 1'b0);
    steps(40);
    do_stop();
    steps(2);

    // Burst of 5 toggles at div=1.
    do_load(1, 5, 1'b1);
    steps(14);

    // Enable gap of 4 cycles mid-count, continuous div=2.
    do_load(2, 0, 1'b0);
    steps(4);
    en = 1'b0;
    steps(4);
    en = 1'b1;
    steps(10);
    do_stop();

    // div=0 burst of 3, then an empty burst.
    do_load(0, 3, 1'b1);
    steps(5);
    do_load(4, 0, 1'b1);
    steps(3);

    // Manual toggles in IDLE.
    for (int i = 0; i < 3; i++) begin
      toggle = 1'b1;
      step();
      step();
    end

    // Toggle ignored during RUN; load beats toggle.
    toggle = 1'b1;
    do_load(4, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      toggle = 1'b1;
      step();
    end

    // load and stop together: stop wins.
    stop = 1'b1;
    do_load(2, 4, 1'b1);
    steps(4);

    // Reload while running: div 5 then 1.
    do_load(5, 0, 1'b0);
    steps(3);
    do_load(1, 0, 1'b0);
    steps(6);
    do_stop();

    // Async reset mid-burst with out=1 and three toggles remaining.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    do_load(1, 6, 1'b1);
    steps(6);
    check("pre_reset_out", out, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_out", out, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_done", done, 1'b0);
    check("async_tick", tick, 1'b0);
    steps(2);
    rst = 1'b1;
    steps(6);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      int r;
      en        = ($urandom_range(0, 7) != 0);
      r         = $urandom_range(0, 31);
      load      = (r < 2);
      stop      = (r == 2);
      toggle    = (r >= 3 && r <= 5);
      div       = DIV_W'($urandom_range(0, 5));
      burst_len = CNT_W'($urandom_range(0, 7));
      mode      = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
